cnu_msg_expand: RTL and testbench
=================================

# cnu_msg_expand

Check-node output expander for the min-sum LDPC decoder. It takes the compressed check-node state produced by the CNU compare tree: minimum, second minimum, index of the minimum, and per-edge sign bits. It then serially emits one check-to-variable message per edge of the row, in sign-magnitude form, with optional offset correction. It sits between the CNU and the variable-node message memory and uses valid/ready handshakes on both sides.

## Interface
- `data_w`, 9: magnitude width; same as the compare-tree data width.
- `idx_w`, 3: edge index width.
- `deg`, 8: row degree (edges per check node); 2 ≤ deg ≤ 2^idx_w.
- `offset`, 0: offset-min-sum correction subtracted from every magnitude.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  compressed record valid.
- `in_ready`  out  1  record accepted when in_valid & in_ready.
- `in_min1`  in  data_w  smallest magnitude.
- `in_min2`  in  data_w  second-smallest magnitude.
- `in_idx`  in  idx_w  edge index of in_min1.
- `in_sgn`  in  deg  per-edge input sign bits; bit i is edge i; 1 = negative.
- `out_valid`  out  1  message valid.
- `out_ready`  in  1  message consumed when out_valid & out_ready.
- `out_msg`  out  data_w+1  {sign, magnitude}.
- `out_idx`  out  idx_w  edge index of out_msg.
- `out_last`  out  1  high on the edge deg-1 beat.

## Operation
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - EMIT: out_valid=1, edge counter `cnt` steps 0..deg-1.
- Transitions:
  - IDLE → EMIT on input handshake; `cnt` is set to 0.
  - EMIT: on each output handshake, `cnt` increments.
  - On the handshake with cnt=deg-1:
    - If an input handshake occurs in the same cycle, stay in EMIT with cnt=0 and the new record.
    - Otherwise go to IDLE.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). This back-to-back path has zero bubbles.
- The accepted record is latched into holding registers. Input pins are ignored at all other times.
- Sign:
  - P = XOR of all deg bits of the latched in_sgn.
  - Sign of edge i = P ^ sgn[i], i.e. the product of all other edges' signs.
- Magnitude:
  - m = (i == idx) ? min2 : min1.
  - mag = (m > offset) ? m − offset : 0, unsigned and saturating at 0.
  - No extra width is used; `offset` must fit in data_w.
- If mag == 0, the sign bit is forced to 0 (no negative zero).
- If the latched idx ≥ deg, no edge matches and every edge receives min1.
- out_idx = cnt; out_last = (cnt == deg-1) & out_valid.
- out_msg, out_idx and out_last hold stable while out_valid & ~out_ready (AXI-style; no retraction).

## Timing
- Reset, rst_n sampled low at a clk edge:
  - Next cycle: state=IDLE, cnt=0, out_valid=0, out_last=0, out_msg=0, out_idx=0; holding registers cleared.
  - in_ready=1 from the first cycle after reset.
- Reset mid-EMIT aborts the record with no further beats. The partial record is dropped.
- Latency: input handshake at edge N → first beat (edge 0) valid in cycle N+1.
- Throughput: one message per cycle with out_ready held high. Records stream with no idle cycle between the last beat of one record and edge 0 of the next.
- A record occupies exactly deg output beats. Any out_ready stall extends it one cycle per stalled cycle.
- Message datapath is combinational from holding registers and `cnt`. in_ready depends combinationally on out_ready; there is no path from in_valid to out_*.

## Test plan
- **Basic expand.** deg=8, offset=0, min1=3, min2=7, idx=5, sgn=8'b0000_0100, out_ready=1.
  - Expect 8 beats starting the cycle after acceptance.
  - Edges 0–4 and 6–7: magnitude 3; edge 5: magnitude 7.
  - Sign (P=1): edge 2 positive, all others negative.
  - out_last only on edge 7.
- **Offset saturation.** offset=4, min1=2, min2=9, idx=0, sgn=0.
  - Edge 0 → {0,5}.
  - Edges 1–7 → {0,0}, including when sign is forced positive with sgn=8'h01.
- **Backpressure.** Toggle out_ready 1,0,0,1,...
  - out_msg and out_idx are stable during stalls; no beat is lost or duplicated.
  - Exactly 8 handshakes occur with idx 0..7 in order.
- **Back-to-back.** Two records offered continuously with out_ready=1.
  - in_ready pulses on the edge-7 beat; the second record's edge 0 follows with no gap.
  - 16 beats over 16 consecutive cycles.
- **Reset mid-record.** Assert rst_n=0 after 3 beats.
  - Next cycle out_valid=0 and in_ready=1.
  - A new record emits from edge 0 with no stale data.
- **Out-of-range idx.** deg=6, idx=7.
  - All 6 beats carry min1; out_last is on edge 5.

Source files
------------

// File: rtl/cnu_msg_expand.sv
// Check-node output expander: turns a compressed min-sum record into deg
// serial sign-magnitude check-to-variable messages, with optional offset.
module cnu_msg_expand #(
  parameter int data_w = 9,
  parameter int idx_w  = 3,
  parameter int deg    = 8,
  parameter int offset = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [data_w-1:0] in_min1,
  input  logic [data_w-1:0] in_min2,
  input  logic [idx_w-1:0]  in_idx,
  input  logic [deg-1:0]    in_sgn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [data_w:0]   out_msg,
  output logic [idx_w-1:0]  out_idx,
  output logic              out_last
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [idx_w-1:0]  LAST_CNT = idx_w'(deg - 1);
  localparam logic [data_w-1:0] OFF      = data_w'(offset);

  state_t            state, state_nxt;
  logic [idx_w-1:0]  cnt, cnt_nxt;
  logic [data_w-1:0] min1_q, min2_q;
  logic [idx_w-1:0]  idx_q;
  logic [deg-1:0]    sgn_q;

  logic              in_hs, out_hs;
  logic              parity;
  logic [data_w-1:0] sel_mag, mag;
  logic              sign_bit;

  assign out_valid = (state == EMIT);
  assign out_last  = out_valid & (cnt == LAST_CNT);
  assign out_hs    = out_valid & out_ready;
  // Accepting on the final beat lets records stream with no bubble.
  assign in_ready  = (state == IDLE) | (out_hs & out_last);
  assign in_hs     = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (in_hs) begin
          state_nxt = EMIT;
          cnt_nxt   = '0;
        end
      end
      EMIT: begin
        if (out_hs) begin
          if (out_last) begin
            state_nxt = in_hs ? EMIT : IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min1_q <= '0;
      min2_q <= '0;
      idx_q  <= '0;
      sgn_q  <= '0;
    end else if (in_hs) begin
      min1_q <= in_min1;
      min2_q <= in_min2;
      idx_q  <= in_idx;
      sgn_q  <= in_sgn;
    end
  end

  // An idx at or beyond deg never equals cnt, so every edge falls back to min1.
  always_comb begin
    parity   = ^sgn_q;
    sel_mag  = (cnt == idx_q) ? min2_q : min1_q;
    mag      = (sel_mag > OFF) ? (sel_mag - OFF) : '0;
    sign_bit = (parity ^ sgn_q[cnt]) & (mag != '0);
  end

  assign out_msg = {sign_bit, mag};
  assign out_idx = cnt;

endmodule

// File: tb/tb_cnu_msg_expand.sv
// Bench for cnu_msg_expand: three instances (plain, offset=4, deg=6) checked
// every cycle against a record-level model, plus hand-computed beat values.
module tb_cnu_msg_expand;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid [3];
  logic [8:0] in_min1, in_min2;
  logic [2:0] in_idx;
  logic [7:0] in_sgn;
  logic       out_ready;

  logic       in_ready_w  [3];
  logic       out_valid_w [3];
  logic [9:0] out_msg_w   [3];
  logic [2:0] out_idx_w   [3];
  logic       out_last_w  [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  int deg_of [3] = '{8, 8, 6};
  int off_of [3] = '{0, 4, 0};

  // Record-level model state.
  bit         m_busy [3];
  int         m_cnt  [3];
  int         m_min1 [3], m_min2 [3], m_idx [3];
  logic [7:0] m_sgn  [3];
  bit         m_acc  [3];
  int         m_acc_cyc [3];

  typedef struct {
    int         k;
    int         cyc;
    logic [9:0] msg;
    logic [2:0] idx;
    logic       last;
  } beat_t;
  beat_t beats [$];

  always #5 clk = ~clk;

  cnu_msg_expand #(.data_w(9), .idx_w(3), .deg(8), .offset(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .in_min1(in_min1), .in_min2(in_min2), .in_idx(in_idx), .in_sgn(in_sgn),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_msg(out_msg_w[0]),
    .out_idx(out_idx_w[0]), .out_last(out_last_w[0]));

  cnu_msg_expand #(.data_w(9), .idx_w(3), .deg(8), .offset(4)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .in_min1(in_min1), .in_min2(in_min2), .in_idx(in_idx), .in_sgn(in_sgn),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_msg(out_msg_w[1]),
    .out_idx(out_idx_w[1]), .out_last(out_last_w[1]));

  cnu_msg_expand #(.data_w(9), .idx_w(3), .deg(6), .offset(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
    .in_min1(in_min1), .in_min2(in_min2), .in_idx(in_idx), .in_sgn(in_sgn[5:0]),
    .out_valid(out_valid_w[2]), .out_ready(out_ready), .out_msg(out_msg_w[2]),
    .out_idx(out_idx_w[2]), .out_last(out_last_w[2]));

  task automatic checkOutput(input string name, input int k,
                             input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s dut%0d: got %0h want %0h (cycle %0d)", name, k, act, exp, cyc);
    end
  endtask

  // Sign is the product of every other edge's sign; magnitude saturates at 0.
  function automatic logic [9:0] exp_msg(input int k, input int i);
    logic neg;
    int   m, mag;
    neg = 1'b0;
    for (int j = 0; j < deg_of[k]; j++)
      if (j != i) neg = neg ^ m_sgn[k][j];
    m   = (i == m_idx[k]) ? m_min2[k] : m_min1[k];
    mag = m - off_of[k];
    if (mag < 0) mag = 0;
    if (mag == 0) neg = 1'b0;
    return {neg, 9'(mag)};
  endfunction

  always @(posedge clk) begin
    bit rdy, ohs, ihs;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 1'b0;
      if (!rst_n) begin
        m_busy[k] = 1'b0;
        m_cnt[k]  = 0;
      end else begin
        rdy = !m_busy[k] || (out_ready && m_cnt[k] == deg_of[k] - 1);
        ohs = m_busy[k] && out_ready;
        ihs = in_valid[k] && rdy;
        if (ohs) begin
          if (m_cnt[k] == deg_of[k] - 1) begin
            m_busy[k] = 1'b0;
            m_cnt[k]  = 0;
          end else begin
            m_cnt[k]++;
          end
        end
        if (ihs) begin
          m_busy[k]    = 1'b1;
          m_cnt[k]     = 0;
          m_min1[k]    = int'(in_min1);
          m_min2[k]    = int'(in_min2);
          m_idx[k]     = int'(in_idx);
          m_sgn[k]     = in_sgn;
          m_acc[k]     = 1'b1;
          m_acc_cyc[k] = cyc;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic exp_rdy;
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        exp_rdy = !m_busy[k] || (out_ready && m_cnt[k] == deg_of[k] - 1);
        checkOutput("in_ready", k, 32'(in_ready_w[k]), 32'(exp_rdy));
        checkOutput("out_valid", k, 32'(out_valid_w[k]), 32'(m_busy[k]));
        if (m_busy[k]) begin
          checkOutput("out_msg", k, 32'(out_msg_w[k]), 32'(exp_msg(k, m_cnt[k])));
          checkOutput("out_idx", k, 32'(out_idx_w[k]), 32'(m_cnt[k]));
          checkOutput("out_last", k, 32'(out_last_w[k]),
                      32'(m_cnt[k] == deg_of[k] - 1));
        end else begin
          checkOutput("out_last_idle", k, 32'(out_last_w[k]), 32'd0);
        end
        if (out_valid_w[k] && out_ready)
          beats.push_back('{k: k, cyc: cyc, msg: out_msg_w[k],
                            idx: out_idx_w[k], last: out_last_w[k]});
      end
    end
  end

  task automatic applyStimulus(input int k, input int min1, input int min2,
                               input int idx, input logic [7:0] sgn);
    bit done;
    done        = 1'b0;
    in_min1     = 9'(min1);
    in_min2     = 9'(min2);
    in_idx      = 3'(idx);
    in_sgn      = sgn;
    in_valid[k] = 1'b1;
    for (int t = 0; t < 60 && !done; t++) begin
      @(posedge clk);
      #1;
      done = m_acc[k];
    end
    in_valid[k] = 1'b0;
    if (!done) checkOutput("accept_timeout", k, 32'd0, 32'd1);
  endtask

  task automatic waitIdle(input int k);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(posedge clk);
      #1;
      done = !m_busy[k];
    end
    if (!done) checkOutput("idle_timeout", k, 32'd0, 32'd1);
  endtask

  task automatic checkReset(input int k);
    checkOutput("rst_in_ready", k, 32'(in_ready_w[k]), 32'd1);
    checkOutput("rst_out_valid", k, 32'(out_valid_w[k]), 32'd0);
    checkOutput("rst_out_msg", k, 32'(out_msg_w[k]), 32'd0);
    checkOutput("rst_out_idx", k, 32'(out_idx_w[k]), 32'd0);
    checkOutput("rst_out_last", k, 32'(out_last_w[k]), 32'd0);
  endtask

  initial begin
    int acc;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_min1   = '0;
    in_min2   = '0;
    in_idx    = '0;
    in_sgn    = '0;
    for (int k = 0; k < 3; k++) in_valid[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) checkReset(k);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic expand");
    beats.delete();
    applyStimulus(0, 3, 7, 5, 8'b0000_0100);
    acc = m_acc_cyc[0];
    waitIdle(0);
    checkOutput("basic_count", 0, 32'(beats.size()), 32'd8);
    checkOutput("basic_latency", 0, 32'(beats[0].cyc), 32'(acc));
    checkOutput("basic_e0", 0, 32'(beats[0].msg), 32'h203);
    checkOutput("basic_e2", 0, 32'(beats[2].msg), 32'h003);
    checkOutput("basic_e5", 0, 32'(beats[5].msg), 32'h207);
    checkOutput("basic_e6_last", 0, 32'(beats[6].last), 32'd0);
    checkOutput("basic_e7_last", 0, 32'(beats[7].last), 32'd1);

    $display("[TB] offset saturation");
    beats.delete();
    applyStimulus(1, 2, 9, 0, 8'h00);
    waitIdle(1);
    checkOutput("off_e0", 1, 32'(beats[0].msg), 32'h005);
    checkOutput("off_e1", 1, 32'(beats[1].msg), 32'h000);
    checkOutput("off_e7", 1, 32'(beats[7].msg), 32'h000);
    beats.delete();
    applyStimulus(1, 2, 9, 0, 8'h01);
    waitIdle(1);
    checkOutput("off_neg_e0", 1, 32'(beats[0].msg), 32'h005);
    checkOutput("off_neg_e3", 1, 32'(beats[3].msg), 32'h000);

    $display("[TB] backpressure");
    beats.delete();
    applyStimulus(0, 10, 20, 3, 8'hA5);
    for (int t = 0; t < 40 && m_busy[0]; t++) begin
      out_ready = (t % 4 == 0) || (t % 4 == 3);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    waitIdle(0);
    checkOutput("bp_count", 0, 32'(beats.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      checkOutput("bp_order", 0, 32'(beats[i].idx), 32'(i));

    $display("[TB] back-to-back");
    beats.delete();
    applyStimulus(0, 1, 2, 0, 8'h00);
    applyStimulus(0, 5, 6, 1, 8'hFF);
    waitIdle(0);
    checkOutput("b2b_count", 0, 32'(beats.size()), 32'd16);
    checkOutput("b2b_span", 0, 32'(beats[15].cyc - beats[0].cyc), 32'd15);
    checkOutput("b2b_a_e0", 0, 32'(beats[0].msg), 32'h002);
    checkOutput("b2b_a_last", 0, 32'(beats[7].last), 32'd1);
    checkOutput("b2b_b_idx", 0, 32'(beats[8].idx), 32'd0);
    checkOutput("b2b_b_e0", 0, 32'(beats[8].msg), 32'h205);
    checkOutput("b2b_b_e1", 0, 32'(beats[9].msg), 32'h206);

    $display("[TB] reset mid-record");
    applyStimulus(0, 8, 12, 2, 8'h03);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkReset(0);
    rst_n = 1'b1;
    beats.delete();
    applyStimulus(0, 6, 9, 0, 8'h00);
    waitIdle(0);
    checkOutput("rst_new_count", 0, 32'(beats.size()), 32'd8);
    checkOutput("rst_new_idx", 0, 32'(beats[0].idx), 32'd0);
    checkOutput("rst_new_e0", 0, 32'(beats[0].msg), 32'h009);
    checkOutput("rst_new_e1", 0, 32'(beats[1].msg), 32'h006);

    $display("[TB] out-of-range idx");
    beats.delete();
    applyStimulus(2, 4, 11, 7, 8'h2C);
    waitIdle(2);
    checkOutput("oor_count", 2, 32'(beats.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      checkOutput("oor_mag", 2, 32'(beats[i].msg[8:0]), 32'd4);
    checkOutput("oor_e0", 2, 32'(beats[0].msg), 32'h204);
    checkOutput("oor_e2", 2, 32'(beats[2].msg), 32'h004);
    checkOutput("oor_last", 2, 32'(beats[5].last), 32'd1);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
